// File: rtl/btn_input_reader_pkg.sv
// Shared definitions for the button/switch input reader: debounce state encoding
// and default sizing.
package btn_input_reader_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 20;
    localparam int SW_W                    = 8;

endpackage

// File: rtl/btn_input_reader_debounce_cell.sv
// One push-button: 2-flop synchroniser, debounce FSM with stability counter,
// registered level plus single-cycle press/release events.
module debounce_cell
    import btn_input_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [1:0]       r_sync;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_s;

    assign w_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_state   <= STABLE_LO;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Counter holds the number of consecutive cycles the new level has been seen
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            STABLE_LO: if (w_s) begin
                w_state_nxt = WAIT_HI;
                w_cnt_nxt   = ONE_CNT;
            end
            WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE_CNT;
                end
            end
            STABLE_HI: if (!w_s) begin
                w_state_nxt = WAIT_LO;
                w_cnt_nxt   = ONE_CNT;
            end
            WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nxt   = STABLE_LO;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE_CNT;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_input_reader.sv
// Debounced push-button events plus a switch-word capture on btn[0], handed to
// the LED sequencer over valid/ready with sticky overrun on dropped presses.
module btn_input_reader
    import btn_input_reader_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic [SW_W-1:0]  sw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [SW_W-1:0]  pattern,
    output logic             pattern_valid,
    input  logic             pattern_ready,
    output logic             overrun
);

    logic [SW_W-1:0] r_sw_meta;
    logic [SW_W-1:0] r_sw_sync;
    logic [SW_W-1:0] r_pattern;
    logic            r_valid;
    logic            r_overrun;
    logic            w_cap_press;
    logic            w_handshake;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .i_btn    (btn[g]),
            .o_level  (btn_level[g]),
            .o_press  (btn_press[g]),
            .o_release(btn_release[g])
        );
    end

    assign w_cap_press = btn_press[0];
    assign w_handshake = r_valid & pattern_ready;

    // A press is accepted when the slot is free or being emptied this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_pattern <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_cap_press && (!r_valid || w_handshake)) begin
                r_pattern <= r_sw_sync;
                r_valid   <= 1'b1;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end else if (w_cap_press) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign pattern       = r_pattern;
    assign pattern_valid = r_valid;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_btn_input_reader.sv
// Directed bench for btn_input_reader with a short debounce window (4 cycles).
module tb_btn_input_reader;

    localparam int N_BTN = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn;
    logic [7:0]       sw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [7:0]       pattern;
    logic             pattern_valid;
    logic             pattern_ready;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    btn_input_reader #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .sw           (sw),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_release  (btn_release),
        .pattern      (pattern),
        .pattern_valid(pattern_valid),
        .pattern_ready(pattern_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        btn           = '1;
        sw            = 8'hFF;
        pattern_ready = 1'b0;

        // 1: reset with all inputs high
        tick(2);
        chk("rst_level", 32'(btn_level), 32'h0);
        chk("rst_press", 32'(btn_press), 32'h0);
        chk("rst_release", 32'(btn_release), 32'h0);
        chk("rst_pattern", 32'(pattern), 32'h0);
        chk("rst_valid", 32'(pattern_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        tick(5);
        chk("post_rst_level_early", 32'(btn_level), 32'h0);
        tick(1);
        chk("post_rst_level", 32'(btn_level), 32'hF);
        chk("post_rst_press", 32'(btn_press), 32'hF);
        tick(1);
        chk("post_rst_press_once", 32'(btn_press), 32'h0);
        chk("post_rst_valid", 32'(pattern_valid), 32'h1);
        chk("post_rst_pattern", 32'(pattern), 32'hFF);
        pattern_ready = 1'b1;
        tick(1);
        pattern_ready = 1'b0;
        chk("post_rst_drain", 32'(pattern_valid), 32'h0);
        btn = '0;
        tick(5);
        chk("all_rel_early", 32'(btn_level), 32'hF);
        tick(1);
        chk("all_rel_level", 32'(btn_level), 32'h0);
        chk("all_rel_release", 32'(btn_release), 32'hF);
        tick(1);
        chk("all_rel_once", 32'(btn_release), 32'h0);

        // 2: clean press and release on btn[1]
        btn = 4'b0010;
        tick(5);
        chk("b1_early", 32'(btn_level), 32'h0);
        tick(1);
        chk("b1_level", 32'(btn_level), 32'h2);
        chk("b1_press", 32'(btn_press), 32'h2);
        tick(1);
        chk("b1_press_once", 32'(btn_press), 32'h0);
        chk("b1_level_hold", 32'(btn_level), 32'h2);
        btn = 4'b0000;
        tick(5);
        chk("b1_rel_early", 32'(btn_level), 32'h2);
        tick(1);
        chk("b1_rel_level", 32'(btn_level), 32'h0);
        chk("b1_release", 32'(btn_release), 32'h2);
        tick(1);
        chk("b1_release_once", 32'(btn_release), 32'h0);

        // 3: bouncing btn[2] never qualifies
        for (int i = 0; i < 18; i++) begin
            if (i % 2 == 0) btn[2] = ~btn[2];
            tick(1);
            chk("bounce_level", 32'(btn_level[2]), 32'h0);
            chk("bounce_press", 32'(btn_press[2]), 32'h0);
            chk("bounce_release", 32'(btn_release[2]), 32'h0);
        end
        btn[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("bounce_settle_level", 32'(btn_level[2]), 32'h0);
            chk("bounce_settle_press", 32'(btn_press[2]), 32'h0);
            chk("bounce_settle_release", 32'(btn_release[2]), 32'h0);
        end

        // 4: capture A5, later switch changes ignored, handshake clears valid
        sw = 8'hA5;
        tick(3);
        btn = 4'b0001;
        tick(7);
        chk("cap_valid", 32'(pattern_valid), 32'h1);
        chk("cap_pattern", 32'(pattern), 32'hA5);
        chk("cap_overrun", 32'(overrun), 32'h0);
        sw = 8'h3C;
        tick(4);
        chk("cap_hold_pattern", 32'(pattern), 32'hA5);
        chk("cap_hold_valid", 32'(pattern_valid), 32'h1);
        pattern_ready = 1'b1;
        tick(1);
        pattern_ready = 1'b0;
        chk("cap_hs_valid", 32'(pattern_valid), 32'h0);
        chk("cap_hs_pattern", 32'(pattern), 32'hA5);
        btn = 4'b0000;
        tick(7);

        // 5: overrun, then back-to-back handoff
        sw = 8'hA5;
        tick(3);
        btn = 4'b0001;
        tick(7);
        chk("ovr_setup_valid", 32'(pattern_valid), 32'h1);
        btn = 4'b0000;
        tick(7);
        sw = 8'hFF;
        tick(3);
        btn = 4'b0001;
        tick(7);
        chk("ovr_pattern", 32'(pattern), 32'hA5);
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_valid", 32'(pattern_valid), 32'h1);
        btn = 4'b0000;
        tick(7);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        sw = 8'h5A;
        tick(3);
        btn = 4'b0001;
        tick(6);
        chk("b2b_press", 32'(btn_press[0]), 32'h1);
        pattern_ready = 1'b1;
        tick(1);
        pattern_ready = 1'b0;
        chk("b2b_valid", 32'(pattern_valid), 32'h1);
        chk("b2b_pattern", 32'(pattern), 32'h5A);
        chk("b2b_overrun", 32'(overrun), 32'h1);
        btn = 4'b0000;
        tick(7);

        // 6: reset mid-debounce (btn[3] at count 2) and mid-handshake
        btn = 4'b1000;
        tick(4);
        chk("mid_level_pre", 32'(btn_level), 32'h0);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_level", 32'(btn_level), 32'h0);
        chk("mid_rst_press", 32'(btn_press), 32'h0);
        chk("mid_rst_valid", 32'(pattern_valid), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        chk("mid_rst_pattern", 32'(pattern), 32'h0);
        rst = 1'b0;
        tick(5);
        chk("mid_after_early", 32'(btn_level), 32'h0);
        chk("mid_after_nopress", 32'(btn_press), 32'h0);
        tick(1);
        chk("mid_after_level", 32'(btn_level), 32'h8);
        chk("mid_after_press", 32'(btn_press), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
